freq_meter: RTL
===============

// Module: freq_meter
// PURPOSE
//  Measures the frequency of an external square wave, e.g. one output bit of
//  the 2/5/9 Hz divider, by counting its rising edges over a fixed gate window
//  of GATE clk cycles (default 1 s at 25 MHz).
//  It is the receiving end of the divider outputs and is used for on-board
//  self-check of the generated rates.
//  One result is produced per window, with a single-cycle valid strobe.
// PARAMETERS
//  GATE   25000000  clk cycles per measurement window (>=4)
//  NG     25        gate counter width; 2**NG >= GATE
//  CW     8         edge-count / result width
// PORTS
//  clk      in   1   system clock, 25 MHz nominal
//  reset_n  in   1   asynchronous, active-low reset
//  en       in   1   1 = measure continuously; 0 = stop and abort window
//  sig_in   in   1   signal under test, asynchronous to clk
//  freq     out  CW  rising edges counted in last completed window (Hz at default GATE)
//  valid    out  1   one-cycle strobe: freq/ovf updated this cycle
//  ovf      out  1   last completed window saturated at 2**CW-1
//  busy     out  1   1 while a window is in progress (state RUN)
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE; freq=0, valid=0, ovf=0, busy=0;
//   synchronizer flops, gate_cnt, edge_cnt cleared.
//  Input path: sig_in -> s1 -> s2 (2-flop sync) -> s3. edge = s2 & ~s3.
//   A sig_in rise is counted 3 clk later; pulses <2 clk wide may be missed.
//  FSM states IDLE, RUN:
//   IDLE: busy=0, gate_cnt=0, edge_cnt=0.
//     en=1 -> RUN next cycle; gate_cnt=0 in the first RUN cycle.
//   RUN: busy=1. Each cycle gate_cnt++ and edge_cnt += edge (saturating).
//     At gate_cnt==GATE-1 (last window cycle):
//       the edge of this cycle is included;
//       next cycle: freq<=final count, ovf<=saturated, valid=1;
//       gate_cnt and edge_cnt restart at 0 (edge in the restart cycle counts
//       into the new window).
//     No dead cycle between windows: window k+1 starts right after window k.
//     en=0 in any RUN cycle -> IDLE next cycle; window aborted, no valid;
//       freq/ovf keep the last completed result.
//     en=0 on the last window cycle -> abort wins; no result.
//  Saturation: edge_cnt stops at 2**CW-1; further edges in that window set
//   the internal sat flag (cleared at window start); ovf=sat at update.
//  valid is high exactly 1 cycle per completed window; never during IDLE.
//  freq/ovf change only on valid cycles or on reset.
//  Reset mid-window: immediate IDLE, all outputs 0, no valid.
//  sig_in static (0 or 1) -> freq=0 each window; a constant 1 at en rise
//   gives no edge.
// TESTING (bench params GATE=100, CW=4 unless noted)
//  1 Reset: reset_n=0 with en=1, sig_in toggling
//      -> freq=0, valid=0, ovf=0, busy=0 throughout.
//  2 Period 10 clk, en=1 held: every window after the first
//      -> valid every 100 clk, freq=10, ovf=0.
//  3 Period 5 clk (20 edges/window), CW=4 -> freq=15, ovf=1.
//      Then period 25 -> next full window freq=4, ovf=0.
//  4 Abort: drop en at gate_cnt=50
//      -> no valid, busy=0 next cycle, freq holds 10.
//      Re-raise en -> first valid 101 clk later.
//  5 Boundary: single sig_in rise timed so edge lands at gate_cnt=GATE-1
//      -> counted in ending window (freq=1); at gate_cnt=0 of next window
//      -> counted in next window.
//  6 Default params, 25 MHz clk, sig_in from divider 2/5/9 Hz outputs
//      -> steady-state freq=2/5/9 (+-1), valid every 25e6 clk.

Source files
------------

// File: rtl/freq_meter.sv
// Rising-edge frequency meter: counts synchronized sig_in rises over a gate
// window of GATE clk cycles and publishes one saturating result per window.
module freq_meter #(
  parameter int unsigned GATE = 25000000,
  parameter int unsigned NG   = 25,
  parameter int unsigned CW   = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          sig_in,
  output logic [CW-1:0] freq,
  output logic          valid,
  output logic          ovf,
  output logic          busy
);

  localparam logic [NG-1:0] GATE_LAST = NG'(GATE - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_d;
  logic          s1, s2, s3;
  logic          rise_c;
  logic [NG-1:0] gate_cnt, gate_d;
  logic [CW-1:0] edge_cnt, edge_d, cnt_inc;
  logic          sat, sat_d, sat_inc;
  logic [CW-1:0] freq_d;
  logic          ovf_d, valid_d;

  // Two-flop synchronizer plus one delay stage for rise detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_c = s2 & ~s3;

  // Saturating edge count including this cycle's rise
  always_comb begin
    cnt_inc = edge_cnt;
    sat_inc = sat;
    if (rise_c) begin
      if (edge_cnt == CNT_MAX) sat_inc = 1'b1;
      else                     cnt_inc = edge_cnt + CW'(1);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state;
    gate_d  = gate_cnt;
    edge_d  = edge_cnt;
    sat_d   = sat;
    freq_d  = freq;
    ovf_d   = ovf;
    valid_d = 1'b0;
    case (state)
      IDLE: begin
        gate_d = '0;
        edge_d = '0;
        sat_d  = 1'b0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          // Abort wins even on the last window cycle
          state_d = IDLE;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end else if (gate_cnt == GATE_LAST) begin
          freq_d  = cnt_inc;
          ovf_d   = sat_inc;
          valid_d = 1'b1;
          gate_d  = '0;
          edge_d  = '0;
          sat_d   = 1'b0;
        end else begin
          gate_d = gate_cnt + NG'(1);
          edge_d = cnt_inc;
          sat_d  = sat_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq     <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      gate_cnt <= gate_d;
      edge_cnt <= edge_d;
      sat      <= sat_d;
      freq     <= freq_d;
      ovf      <= ovf_d;
      valid    <= valid_d;
      busy     <= (state_d == RUN);
    end
  end

endmodule
